// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM arbiter: video fetch has absolute priority, the CPU
// takes every free slot. Tags travel alongside each access to route the returned data.
module vram_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 9,
    parameter int MAX_WAIT = 64
) (
    input  logic              CLK1_50,
    input  logic              RST,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic [DATA_W-1:0] VID_DATA,
    output logic              VID_VALID,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_ACK,
    output logic              CPU_STARVE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {T_NONE, T_VID, T_CPU_RD, T_CPU_WR} tag_t;
    typedef enum logic {C_IDLE, C_BUSY} cpu_st_t;

    cpu_st_t          state, state_nxt;
    tag_t             tag_iss, tag_ret;
    logic             cpu_grant;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;

    always_ff @(posedge CLK1_50) begin
        if (RST) state <= C_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            C_IDLE: if (cpu_grant) state_nxt = C_BUSY;
            C_BUSY: if (CPU_ACK)   state_nxt = C_IDLE;
            default:               state_nxt = C_IDLE;
        endcase
    end

    // Staying busy through the ACK cycle keeps a still-held request from being re-issued.
    always_comb begin
        cpu_grant = (state == C_IDLE) && CPU_REQ && !VID_REQ;
    end

    always_comb begin
        wait_nxt = wait_cnt;
        if (!CPU_REQ || cpu_grant)
            wait_nxt = '0;
        else if (state == C_IDLE && wait_cnt != WAIT_MAX)
            wait_nxt = wait_cnt + 1'b1;
    end

    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            wait_cnt   <= '0;
            CPU_STARVE <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_MAX) CPU_STARVE <= 1'b1;
        end
    end

    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            MEM_ADDR  <= '0;
            MEM_WE    <= 1'b0;
            MEM_WDATA <= '0;
            tag_iss   <= T_NONE;
        end else begin
            MEM_WE  <= 1'b0;
            tag_iss <= T_NONE;
            if (VID_REQ) begin
                MEM_ADDR <= VID_ADDR;
                tag_iss  <= T_VID;
            end else if (cpu_grant) begin
                MEM_ADDR  <= CPU_ADDR;
                MEM_WE    <= CPU_WE;
                MEM_WDATA <= CPU_WDATA;
                tag_iss   <= CPU_WE ? T_CPU_WR : T_CPU_RD;
            end
        end
    end

    // Reads return two edges after issue; writes complete one edge after issue.
    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            tag_ret   <= T_NONE;
            VID_VALID <= 1'b0;
            VID_DATA  <= '0;
            CPU_ACK   <= 1'b0;
            CPU_RDATA <= '0;
        end else begin
            tag_ret   <= tag_iss;
            VID_VALID <= (tag_ret == T_VID);
            CPU_ACK   <= (tag_ret == T_CPU_RD) || (tag_iss == T_CPU_WR);
            if (tag_ret == T_VID)    VID_DATA  <= MEM_RDATA;
            if (tag_ret == T_CPU_RD) CPU_RDATA <= MEM_RDATA;
        end
    end

endmodule
